// File: rtl/group_burst_quota.sv
// Burst quota / grant timeout controller for the 4-way bank-group arbiter.
// Optional per-group grant and timeout statistics are enabled by GRP_QUOTA_STATS_EN.
module group_burst_quota #(
  parameter int unsigned NUM_GROUPS  = 4,
  parameter int unsigned MAX_BURSTS  = 8,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CFG_W       = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_GROUPS-1:0]   start_i,
  input  logic                    burst_fire_i,
  input  logic                    cfg_wr_i,
  input  logic [CFG_W-1:0]        cfg_max_bursts_i,
  input  logic [CFG_W-1:0]        cfg_timeout_i,
  output logic [NUM_GROUPS-1:0]   done_o,
  output logic [1:0]              active_group_o,
  output logic [CFG_W-1:0]        burst_cnt_o,
  output logic                    quota_hit_o,
  output logic                    timeout_hit_o,
  output logic                    err_multi_grant_o
`ifdef GRP_QUOTA_STATS_EN
  ,
  output logic [NUM_GROUPS*16-1:0] grant_stats_o,
  output logic [15:0]              timeout_stats_o
`endif
);

  typedef enum logic [1:0] {StIdle, StCount, StRelease} state_e;

  localparam logic [NUM_GROUPS-1:0] GrpOne = {{(NUM_GROUPS-1){1'b0}}, 1'b1};

  state_e                  state_q;
  logic [NUM_GROUPS-1:0]   done_q;
  logic [1:0]              active_group_q;
  logic [CFG_W-1:0]        burst_cnt_q;
  logic [CFG_W-1:0]        timer_q;
  logic [CFG_W-1:0]        shadow_quota_q;
  logic [CFG_W-1:0]        shadow_timeout_q;
  logic [CFG_W-1:0]        quota_q;
  logic [CFG_W-1:0]        timeout_q;
  logic                    quota_hit_q;
  logic                    timeout_hit_q;
  logic                    err_multi_grant_q;

  logic                    start_none;
  logic                    start_onehot;
  logic                    start_multi;
  logic [1:0]              start_idx;
  logic                    same_grp;
  logic                    enter;
  logic [CFG_W:0]          cnt_sum;
  logic [CFG_W:0]          timer_sum;
  logic [CFG_W-1:0]        cnt_inc;
  logic [CFG_W-1:0]        timer_inc;
  logic                    quota_met;
  logic                    timeout_met;

  always_comb begin
    start_none   = (start_i == '0);
    start_onehot = !start_none && ((start_i & (start_i - GrpOne)) == '0);
    start_multi  = !start_none && !start_onehot;
    start_idx    = 2'd0;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      if (start_i[i]) start_idx = 2'(i);
    end
    same_grp = (start_idx == active_group_q);
    // A one-hot grant enters COUNT from IDLE, or from COUNT/RELEASE when it moves groups.
    enter    = start_onehot && ((state_q == StIdle) || !same_grp);

    cnt_sum     = {1'b0, burst_cnt_q} + {{CFG_W{1'b0}}, burst_fire_i};
    timer_sum   = {1'b0, timer_q} + {{CFG_W{1'b0}}, 1'b1};
    cnt_inc     = (&burst_cnt_q) ? burst_cnt_q : cnt_sum[CFG_W-1:0];
    timer_inc   = (&timer_q) ? timer_q : timer_sum[CFG_W-1:0];
    quota_met   = (quota_q != '0) && (cnt_sum >= {1'b0, quota_q});
    timeout_met = (timeout_q != '0) && (timer_sum >= {1'b0, timeout_q});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      done_q            <= '0;
      active_group_q    <= 2'd0;
      burst_cnt_q       <= '0;
      timer_q           <= '0;
      shadow_quota_q    <= CFG_W'(MAX_BURSTS);
      shadow_timeout_q  <= CFG_W'(TIMEOUT_CYC);
      quota_q           <= CFG_W'(MAX_BURSTS);
      timeout_q         <= CFG_W'(TIMEOUT_CYC);
      quota_hit_q       <= 1'b0;
      timeout_hit_q     <= 1'b0;
      err_multi_grant_q <= 1'b0;
    end else begin
      quota_hit_q       <= 1'b0;
      timeout_hit_q     <= 1'b0;
      err_multi_grant_q <= 1'b0;

      if (cfg_wr_i) begin
        shadow_quota_q   <= cfg_max_bursts_i;
        shadow_timeout_q <= cfg_timeout_i;
      end

      if (enter) begin
        state_q        <= StCount;
        done_q         <= '0;
        active_group_q <= start_idx;
        burst_cnt_q    <= '0;
        timer_q        <= '0;
        quota_q        <= shadow_quota_q;
        timeout_q      <= shadow_timeout_q;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_multi) err_multi_grant_q <= 1'b1;
          end
          StCount: begin
            if (start_none) begin
              state_q <= StIdle;
            end else if (start_multi) begin
              err_multi_grant_q <= 1'b1;
              state_q           <= StIdle;
            end else begin
              burst_cnt_q <= cnt_inc;
              timer_q     <= timer_inc;
              if (quota_met || timeout_met) begin
                done_q        <= GrpOne << active_group_q;
                quota_hit_q   <= quota_met;
                timeout_hit_q <= timeout_met;
                state_q       <= StRelease;
              end
            end
          end
          StRelease: begin
            if (start_none) begin
              done_q  <= '0;
              state_q <= StIdle;
            end else if (start_multi) begin
              err_multi_grant_q <= 1'b1;
              done_q            <= '0;
              state_q           <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign done_o            = done_q;
  assign active_group_o    = active_group_q;
  assign burst_cnt_o       = burst_cnt_q;
  assign quota_hit_o       = quota_hit_q;
  assign timeout_hit_o     = timeout_hit_q;
  assign err_multi_grant_o = err_multi_grant_q;

`ifdef GRP_QUOTA_STATS_EN
  logic [15:0] grant_cnt_q [NUM_GROUPS];
  logic [15:0] timeout_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_GROUPS; i++) grant_cnt_q[i] <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (enter && !(&grant_cnt_q[start_idx])) begin
        grant_cnt_q[start_idx] <= grant_cnt_q[start_idx] + 16'd1;
      end
      if (timeout_hit_q && !(&timeout_cnt_q)) begin
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_stats
    assign grant_stats_o[g*16 +: 16] = grant_cnt_q[g];
  end
  assign timeout_stats_o = timeout_cnt_q;
`endif

endmodule
